// File: rtl/mux_arb_nto1.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arb_nto1
//  Purpose  : N-to-1 arbitrating multiplexer with a single registered output
//             slot. A channel is picked either explicitly by index (mode=0) or
//             by a round-robin search that starts just after the last
//             round-robin winner (mode=1). The output slot is held under
//             downstream backpressure.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1         rising-edge clock
//    rst      in   1         asynchronous active-low reset
//    en       in   1         accept enable (blocks new grants only)
//    mode     in   1         0 = explicit select, 1 = round-robin
//    sel      in   selw      channel index used in explicit mode
//    q        in   ch*n      packed channel data, channel i at q[i*n +: n]
//    q_valid  in   ch        per-channel valid
//    q_ready  out  ch        per-channel accept strobe (one-hot on grant)
//    d        out  n         registered output data
//    d_ch     out  selw      source channel of d
//    d_valid  out  1         output valid
//    d_ready  in   1         downstream ready
// ============================================================================
module mux_arb_nto1 #(
   parameter  int n    = 8,
   parameter  int ch   = 4,
   localparam int selw = $clog2(ch)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   input  logic [selw-1:0]   sel,
   input  logic [ch*n-1:0]   q,
   input  logic [ch-1:0]     q_valid,
   output logic [ch-1:0]     q_ready,
   output logic [n-1:0]      d,
   output logic [selw-1:0]   d_ch,
   output logic              d_valid,
   input  logic              d_ready
);

   // Output slot and round-robin pointer state
   logic [n-1:0]    dout_q, dout_d;
   logic [selw-1:0] dch_q,  dch_d;
   logic            dvld_q, dvld_d;
   logic [selw-1:0] ptr_q,  ptr_d;

   // Arbitration
   logic            slot_free;
   logic            cand_found;
   logic [selw-1:0] cand_idx;
   logic [n-1:0]    cand_data;
   logic            grant;
   logic [selw-1:0] rr_j;

   always_comb begin
      slot_free  = ~dvld_q | d_ready;
      cand_found = 1'b0;
      cand_idx   = '0;
      rr_j       = '0;

      if (!mode) begin
         // Explicit: only an in-range index can match, so sel >= ch never grants.
         for (int i = 0; i < ch; i++) begin
            if (sel == selw'(i) && q_valid[i]) begin
               cand_found = 1'b1;
               cand_idx   = selw'(i);
            end
         end
      end else begin
         // Round-robin: cyclic search starting at ptr+1; first hit wins.
         for (int k = 1; k <= ch; k++) begin
            rr_j = selw'((int'(ptr_q) + k) % ch);
            if (!cand_found && q_valid[rr_j]) begin
               cand_found = 1'b1;
               cand_idx   = rr_j;
            end
         end
      end

      cand_data = '0;
      for (int i = 0; i < ch; i++) begin
         if (cand_idx == selw'(i)) begin
            cand_data = q[i*n +: n];
         end
      end

      // rst gates the grant so q_ready is quiet throughout reset.
      grant = rst & en & slot_free & cand_found;

      q_ready = '0;
      if (grant) begin
         q_ready[cand_idx] = 1'b1;
      end

      dout_d = dout_q;
      dch_d  = dch_q;
      dvld_d = dvld_q;
      ptr_d  = ptr_q;
      if (grant) begin
         dout_d = cand_data;
         dch_d  = cand_idx;
         dvld_d = 1'b1;
         if (mode) begin
            ptr_d = cand_idx;
         end
      end else if (slot_free) begin
         dvld_d = 1'b0;
      end
   end

   // ptr resets to ch-1 so the first round-robin search begins at channel 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_q <= '0;
         dch_q  <= '0;
         dvld_q <= 1'b0;
         ptr_q  <= selw'(ch - 1);
      end else begin
         dout_q <= dout_d;
         dch_q  <= dch_d;
         dvld_q <= dvld_d;
         ptr_q  <= ptr_d;
      end
   end

   assign d       = dout_q;
   assign d_ch    = dch_q;
   assign d_valid = dvld_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_nto1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_arb_nto1
//  Purpose  : Self-checking bench for mux_arb_nto1 (n=8, ch=4) comparing the
//             design against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_arb_nto1;
   localparam int N  = 8;
   localparam int CH = 4;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic            mode;
   logic [SW-1:0]   sel;
   logic [CH*N-1:0] q;
   logic [CH-1:0]   q_valid;
   logic [CH-1:0]   q_ready;
   logic [N-1:0]    d;
   logic [SW-1:0]   d_ch;
   logic            d_valid;
   logic            d_ready;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int         m_ptr;
   bit         m_dvalid;
   logic [N-1:0] m_d;
   int         m_dch;

   mux_arb_nto1 #(.n(N), .ch(CH)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .q(q),
      .q_valid(q_valid), .q_ready(q_ready), .d(d), .d_ch(d_ch),
      .d_valid(d_valid), .d_ready(d_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Candidate channel chosen by the rules, or -1 if none.
   function automatic int model_cand();
      if (!mode) begin
         if (int'(sel) < CH && q_valid[sel]) return int'(sel);
         return -1;
      end
      for (int k = 1; k <= CH; k++) begin
         int j;
         j = (m_ptr + k) % CH;
         if (q_valid[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr    = CH - 1;
      m_dvalid = 1'b0;
      m_d      = '0;
      m_dch    = 0;
   endtask

   // Entered between edges with inputs already driven; returns at posedge+1.
   task automatic run_cycle();
      int c;
      bit g;
      logic [CH-1:0] exp_rdy;
      #1;
      c = model_cand();
      g = en && rst && (!m_dvalid || d_ready) && (c >= 0);
      exp_rdy = '0;
      if (g) exp_rdy[c] = 1'b1;
      check("q_ready", 32'(q_ready), 32'(exp_rdy));
      @(posedge clk);
      if (g) begin
         m_d      = q[c*N +: N];
         m_dch    = c;
         m_dvalid = 1'b1;
         if (mode) m_ptr = c;
      end else if (!m_dvalid || d_ready) begin
         m_dvalid = 1'b0;
      end
      #1;
      check("d_valid", 32'(d_valid), 32'(m_dvalid));
      if (m_dvalid) begin
         check("d", 32'(d), 32'(m_d));
         check("d_ch", 32'(d_ch), 32'(m_dch));
      end
   endtask

   // Asserts reset between edges, checks immediate effect, releases after an edge.
   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      #1;
      check("rst_d_valid", 32'(d_valid), 32'd0);
      check("rst_q_ready", 32'(q_ready), 32'd0);
      check("rst_d", 32'(d), 32'd0);
      check("rst_d_ch", 32'(d_ch), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b1; mode = 1'b1; sel = '0; d_ready = 1'b1;
      q = 32'h44332211; q_valid = 4'b1111;
      model_reset();
      @(posedge clk); #1;

      // Reset with all channels valid, then first grant goes to channel 0
      do_reset();
      run_cycle();
      check("first_d_ch", 32'(d_ch), 32'd0);
      check("first_d", 32'(d), 32'h11);

      // Round-robin rotation across all channels
      for (int i = 0; i < 5; i++) run_cycle();

      // Explicit select of channel 2
      mode = 1'b0; sel = 2'd2; q_valid = 4'b0100; q = 32'h00A50000;
      run_cycle();
      check("expl_d", 32'(d), 32'hA5);
      sel = 2'd2; q_valid = 4'b1011;
      run_cycle();
      check("expl_drop", 32'(d_valid), 32'd0);

      // Backpressure: hold three cycles, then release
      mode = 1'b1; q_valid = 4'b1111; q = 32'hDDCCBBAA;
      run_cycle();
      d_ready = 1'b0;
      for (int i = 0; i < 3; i++) run_cycle();
      d_ready = 1'b1;
      run_cycle();

      // Enable low blocks grants, then resumes from ptr+1
      en = 1'b0;
      run_cycle();
      en = 1'b1;
      run_cycle();
      run_cycle();

      // Reset mid-transfer: held word is discarded, rotation restarts at 0
      d_ready = 1'b0;
      run_cycle();
      do_reset();
      d_ready = 1'b1; q_valid = 4'b1111;
      run_cycle();
      check("post_rst_d_ch", 32'(d_ch), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         en      = ($urandom_range(0, 9) != 0);
         mode    = 1'($urandom);
         sel     = SW'($urandom);
         q       = $urandom;
         q_valid = CH'($urandom);
         d_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 99) == 0) do_reset();
         run_cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mux_arb_nto1.md
MUX_ARB_NTO1 -- requirements
Module: mux_arb_nto1

Interface
REQ-001 The block SHALL have parameter n, default 8: data width per channel in bits, minimum 1.
REQ-002 The block SHALL have parameter ch, default 4: number of input channels, range 2..16.
REQ-003 The block SHALL have a derived local parameter selw = clog2(ch).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: accept enable.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = explicit select, 1 = round-robin.
REQ-008 The block SHALL have port sel, input, selw bits: channel index, used in explicit mode only.
REQ-009 The block SHALL have port q, input, ch*n bits: packed channel data, channel i at q[i*n +: n].
REQ-010 The block SHALL have port q_valid, input, ch bits: per-channel valid.
REQ-011 The block SHALL have port q_ready, output, ch bits: per-channel accept strobe.
REQ-012 The block SHALL have port d, output, n bits: registered output data.
REQ-013 The block SHALL have port d_ch, output, selw bits: source channel of d.
REQ-014 The block SHALL have port d_valid, output, 1 bit: output valid.
REQ-015 The block SHALL have port d_ready, input, 1 bit: downstream ready.

Function
REQ-016 The output register SHALL be free when d_valid=0 or d_ready=1 (slot_free).
REQ-017 In explicit mode, candidate SHALL be channel sel, granted only when sel<ch and q_valid[sel]=1; sel>=ch SHALL never grant.
REQ-018 In round-robin mode, candidate SHALL be the first i with q_valid[i]=1, searching cyclically from (ptr+1) mod ch.
REQ-019 A grant SHALL occur in a cycle only when en=1, slot_free=1 and a candidate exists.
REQ-020 q_ready SHALL be combinational and one-hot on the granted channel, with all bits 0 when no grant occurs.
REQ-021 On a grant, d, d_ch and d_valid SHALL take the candidate's data, the candidate index and 1, respectively, at the next rising edge: latency 1 cycle.
REQ-022 If slot_free=1 and there is no grant, d_valid SHALL clear at the edge.
REQ-023 While d_valid=1 and d_ready=0, d and d_ch SHALL hold stable.
REQ-024 Throughput SHALL be one transfer per cycle while d_ready=1.
REQ-025 ptr (selw bits) SHALL update to the granted index only on round-robin-mode grants; explicit-mode grants SHALL leave ptr unchanged.
REQ-026 en=0 SHALL block new grants only; a held output SHALL still drain via d_ready.
REQ-027 A mode or sel change SHALL take effect in the same cycle (combinational).
REQ-028 ptr wrap: after a grant to channel ch-1, the search SHALL start at channel 0.
REQ-029 Simultaneous drain and grant (d_valid=1, d_ready=1, grant) SHALL replace the output with no bubble.

Reset
REQ-030 While rst=0, d_valid SHALL be 0 immediately (asynchronous), with d=0, d_ch=0 and ptr=ch-1, so that channel 0 has first round-robin priority.
REQ-031 While rst=0, q_ready SHALL be all 0.
REQ-032 Reset asserted mid-transfer SHALL discard the held output word, with no replay after reset.
REQ-033 The first grant after reset SHALL be possible on the first rising edge with rst=1.

Verification
REQ-034 Reset: n=8, ch=4; rst=0 with all q_valid=1 -> d_valid=0, q_ready=0000; rst rises, mode=1, en=1, d_ready=1 -> next edge d_ch=0, d=q[7:0].
REQ-035 Round-robin: q_valid=1111, d_ready=1 held -> d_ch sequence 0,1,2,3,0,1 on consecutive cycles; q_ready one-hot 0001,0010,0100,1000,...
REQ-036 Explicit: mode=0, sel=2, q_valid=0100, q[23:16]=8'hA5 -> q_ready=0100, next edge d=A5, d_ch=2; sel=2 with q_valid=1011 -> q_ready=0000, d_valid falls.
REQ-037 Backpressure: d_valid=1, d_ready=0 for 3 cycles with q_valid=1111 -> d, d_ch constant and q_ready=0000; d_ready=1 -> same-cycle grant, new word on next edge.
REQ-038 Enable: en=0, q_valid=1111, d_ready=1 -> q_ready=0000, d_valid falls after one edge; en=1 -> grants resume from ptr+1.
REQ-039 Mid-reset: assert rst=0 between edges while d_valid=1 -> d_valid=0 before the next edge; after release, round-robin restarts at channel 0.
